id_stage_pipe: RTL
==================

// Module: id_stage_pipe
// PURPOSE
//   Parametrised MIPS instruction-decode stage: main control + ALU control, NREG x XLEN register file
//   with write-back port, and a registered ID/EX pipeline boundary with valid/ready handshake.
//   Adds load-use hazard stall, flush, illegal-instruction flag and optional immediate-logic/BNE opcodes.
//   Sits between the fetch stage and the execute stage; write-back arrives from the WB stage.
// PARAMETERS
//   XLEN     32  datapath width (>=16)
//   NREG     32  register count (power of 2, >=2); RAW = $clog2(NREG)
//   EXT_OPS  1   1 = also decode ANDI/ORI/SLTI/BNE; 0 = base set only
// PORTS
//   clk            in   1     clock, rising edge
//   rst_n          in   1     asynchronous reset, active low
//   if_valid       in   1     fetch presents an instruction
//   if_instr       in   32    instruction word
//   id_ready       out  1     stage accepts if_instr this cycle
//   flush          in   1     squash ID/EX contents (branch taken / exception)
//   wb_we          in   1     register write enable
//   wb_addr        in   RAW   write address
//   wb_data        in   XLEN  write data
//   ex_ready       in   1     execute stage accepts ID/EX contents
//   ex_valid       out  1     ID/EX holds a valid instruction
//   ex_rs_data     out  XLEN  operand A; ex_rt_data out XLEN operand B
//   ex_imm         out  XLEN  extended immediate
//   ex_rs/ex_rt/ex_dst out RAW  source / destination register indices
//   ex_alu_ctrl    out  4     0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
//   ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_branch, ex_branch_ne,
//   ex_illegal     out  1 each  registered control bits
// BEHAVIOUR
// - Reset (rst_n=0, async): all registers = 0, every ex_* output = 0, ex_valid = 0; id_ready = 1 after release.
// - Regfile: 1 write / 2 async reads; write at rising clk when wb_we && wb_addr!=0; r0 reads 0 always.
//   Write-through bypass: read of wb_addr in the same cycle as wb_we returns wb_data (r0 excepted).
// - Decode (combinational, then registered):
//   R 000000: rd dest, alu_src0, reg_write1, funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
//   LW 100011: rt dest, alu_src1, mem_read1, mem_to_reg1, reg_write1, add.
//   SW 101011: alu_src1, mem_write1, add.   BEQ 000100: branch1, sub.   ADDI 001000: rt dest, alu_src1, reg_write1, add.
//   EXT_OPS=1: ANDI 001100 and, ORI 001101 or (zero-extend imm); SLTI 001010 slt; BNE 000101 branch_ne1, sub.
//   Unused control bits are 0 (never X). Unknown opcode/funct -> illegal=1, reg_write/mem_read/mem_write/branch* = 0.
//   imm: sign-extend instr[15:0] to XLEN except ANDI/ORI zero-extend. Dest index 0 forces reg_write=0.
//   Register indices truncate instr fields to RAW bits.
// - Handshake: advance = !ex_valid || ex_ready. On advance ID/EX loads decoded fields, ex_valid <= accept.
//   When !advance, ID/EX holds (all ex_* stable), id_ready = 0.
// - Load-use hazard: hazard = ex_valid && ex_mem_read && ex_dst!=0 && (ex_dst==rs || (ex_dst==rt && rt is
//   a source: R, SW, BEQ, BNE)). On hazard with advance: bubble inserted (ex_valid<=0), id_ready=0, instr held.
// - accept = if_valid && id_ready; id_ready = advance && !hazard (forced 1 while flush is high).
// - flush: priority over everything; next edge ex_valid<=0, incoming instruction dropped. Regfile write unaffected.
// - Latency: 1 cycle from accept to ex_valid; throughput 1/cycle without stalls.
// TESTING
// - Reset mid-stream: assert rst_n=0 with ex_valid=1 -> ex_valid, ex_* = 0 immediately; r5 reads 0 afterwards.
// - Write r3=0x1234 then ADD r1,r3,r3 same cycle -> ex_rs_data=ex_rt_data=0x1234, alu_ctrl=0010, dst=1.
// - LW r2,4(r0) then ADD r4,r2,r1 -> one bubble (ex_valid=0), id_ready=0 one cycle, then ADD issues.
// - ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* stable, id_ready=0; resumes on ex_ready=1.
// - ORI r7,r0,0xFFFF -> imm=0x0000FFFF, alu 0001; ADDI same imm -> 0xFFFFFFFF; opcode 111111 -> ex_illegal=1.
// - flush with ex_ready=0 and if_valid=1 -> next cycle ex_valid=0, instruction dropped; wb write of r0 ignored.

Source files
------------

// File: rtl/id_stage_pipe.sv
// MIPS instruction-decode stage: control decode, register file with write-through bypass,
// and a registered ID/EX boundary with valid/ready handshake, load-use stall and flush.
module id_stage_pipe #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int EXT_OPS = 1,
    localparam int RAW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    output logic            id_ready,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [RAW-1:0]  wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_rs_data,
    output logic [XLEN-1:0] ex_rt_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [RAW-1:0]  ex_rs,
    output logic [RAW-1:0]  ex_rt,
    output logic [RAW-1:0]  ex_dst,
    output logic [3:0]      ex_alu_ctrl,
    output logic            ex_alu_src,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_mem_to_reg,
    output logic            ex_reg_write,
    output logic            ex_branch,
    output logic            ex_branch_ne,
    output logic            ex_illegal
);

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] rs_data;
        logic [XLEN-1:0] rt_data;
        logic [XLEN-1:0] imm;
        logic [RAW-1:0]  rs;
        logic [RAW-1:0]  rt;
        logic [RAW-1:0]  dst;
        logic [3:0]      alu_ctrl;
        logic            alu_src;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            reg_write;
        logic            branch;
        logic            branch_ne;
        logic            illegal;
    } idex_t;

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    idex_t           idex_q, idex_d, dec;

    logic [5:0]     opcode, funct;
    logic [4:0]     rs_f, rt_f, rd_f;
    logic [RAW-1:0] rs_idx, rt_idx, rd_idx;
    logic           rt_src, zext, hazard, advance, accept;

    assign opcode = if_instr[31:26];
    assign funct  = if_instr[5:0];
    assign rs_f   = if_instr[25:21];
    assign rt_f   = if_instr[20:16];
    assign rd_f   = if_instr[15:11];
    assign rs_idx = rs_f[RAW-1:0];
    assign rt_idx = rt_f[RAW-1:0];
    assign rd_idx = rd_f[RAW-1:0];

    always_comb begin
        regs_d = regs_q;
        if (wb_we && wb_addr != '0)
            regs_d[wb_addr] = wb_data;
    end

    always_comb begin
        dec         = '0;
        rt_src      = 1'b0;
        zext        = 1'b0;
        dec.rs      = rs_idx;
        dec.rt      = rt_idx;
        // Reads see a same-cycle write-back so WB->ID needs no extra forwarding.
        dec.rs_data = (rs_idx == '0) ? '0 :
                      (wb_we && wb_addr == rs_idx) ? wb_data : regs_q[rs_idx];
        dec.rt_data = (rt_idx == '0) ? '0 :
                      (wb_we && wb_addr == rt_idx) ? wb_data : regs_q[rt_idx];
        case (opcode)
            6'b000000: begin
                dec.dst       = rd_idx;
                dec.reg_write = 1'b1;
                rt_src        = 1'b1;
                case (funct)
                    6'b100000: dec.alu_ctrl = ALU_ADD;
                    6'b100010: dec.alu_ctrl = ALU_SUB;
                    6'b100100: dec.alu_ctrl = ALU_AND;
                    6'b100101: dec.alu_ctrl = ALU_OR;
                    6'b101010: dec.alu_ctrl = ALU_SLT;
                    default:   dec.illegal  = 1'b1;
                endcase
            end
            6'b100011: begin
                dec.dst        = rt_idx;
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec.alu_ctrl   = ALU_ADD;
            end
            6'b101011: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                dec.alu_ctrl  = ALU_ADD;
                rt_src        = 1'b1;
            end
            6'b000100: begin
                dec.branch   = 1'b1;
                dec.alu_ctrl = ALU_SUB;
                rt_src       = 1'b1;
            end
            6'b001000: begin
                dec.dst       = rt_idx;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_ctrl  = ALU_ADD;
            end
            6'b001100, 6'b001101, 6'b001010: begin
                if (EXT_OPS != 0) begin
                    dec.dst       = rt_idx;
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    zext          = (opcode != 6'b001010);
                    dec.alu_ctrl  = (opcode == 6'b001100) ? ALU_AND :
                                    (opcode == 6'b001101) ? ALU_OR  : ALU_SLT;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            6'b000101: begin
                if (EXT_OPS != 0) begin
                    dec.branch_ne = 1'b1;
                    dec.alu_ctrl  = ALU_SUB;
                    rt_src        = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
        // An illegal instruction carries only its flag; no side effect may leak to EX/MEM/WB.
        if (dec.illegal) begin
            dec.dst        = '0;
            dec.alu_ctrl   = '0;
            dec.alu_src    = 1'b0;
            dec.mem_read   = 1'b0;
            dec.mem_write  = 1'b0;
            dec.mem_to_reg = 1'b0;
            dec.reg_write  = 1'b0;
            dec.branch     = 1'b0;
            dec.branch_ne  = 1'b0;
        end
        if (dec.dst == '0)
            dec.reg_write = 1'b0;
        dec.imm = zext ? {{(XLEN-16){1'b0}}, if_instr[15:0]}
                       : {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};
    end

    assign advance  = !idex_q.valid || ex_ready;
    assign hazard   = idex_q.valid && idex_q.mem_read && (idex_q.dst != '0) &&
                      ((idex_q.dst == rs_idx) || ((idex_q.dst == rt_idx) && rt_src));
    assign id_ready = flush || (advance && !hazard);
    assign accept   = if_valid && id_ready;

    always_comb begin
        idex_d = idex_q;
        if (flush) begin
            idex_d.valid = 1'b0;
        end else if (advance) begin
            idex_d       = dec;
            idex_d.valid = accept;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q <= '0;
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
        end else begin
            idex_q <= idex_d;
            regs_q <= regs_d;
        end
    end

    assign ex_valid      = idex_q.valid;
    assign ex_rs_data    = idex_q.rs_data;
    assign ex_rt_data    = idex_q.rt_data;
    assign ex_imm        = idex_q.imm;
    assign ex_rs         = idex_q.rs;
    assign ex_rt         = idex_q.rt;
    assign ex_dst        = idex_q.dst;
    assign ex_alu_ctrl   = idex_q.alu_ctrl;
    assign ex_alu_src    = idex_q.alu_src;
    assign ex_mem_read   = idex_q.mem_read;
    assign ex_mem_write  = idex_q.mem_write;
    assign ex_mem_to_reg = idex_q.mem_to_reg;
    assign ex_reg_write  = idex_q.reg_write;
    assign ex_branch     = idex_q.branch;
    assign ex_branch_ne  = idex_q.branch_ne;
    assign ex_illegal    = idex_q.illegal;

endmodule
